lut_interp_activation: RTL and testbench

Pipelined consumer of the activation-function LUT. It accepts a signed fixed-point pre-activation value and drives the LUT `address` port from that value. It takes back the LUT's combinational `base` and `next__data` outputs and returns the linearly interpolated activation value. It sits between a neuron's accumulator output and the next layer's input, with valid/ready handshakes on both sides.

---
 rtl/lut_interp_activation.sv | 79 +++++++
 tb/tb_lut_interp_activation.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_interp_activation.sv
// rtl/lut_interp_activation.sv - two-stage LUT-interpolating activation with valid/ready handshakes
module lut_interp_activation #(
    parameter int IN_WIDTH   = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FRAC_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic [ADDR_WIDTH-1:0] lut_address,
    input  logic [DATA_WIDTH-1:0] lut_base,
    input  logic [DATA_WIDTH-1:0] lut_next,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int PROD_WIDTH = DATA_WIDTH + 1 + FRAC_WIDTH;

    logic                         r_s1_valid;
    logic [IN_WIDTH-1:0]          r_s1_x;
    logic                         r_out_valid;
    logic [DATA_WIDTH-1:0]        r_out_data;

    logic                         w_advance;
    logic                         w_accept;
    logic [FRAC_WIDTH-1:0]        w_frac;
    logic signed [DATA_WIDTH:0]   w_diff;
    logic signed [PROD_WIDTH-1:0] w_diff_ext;
    logic signed [PROD_WIDTH-1:0] w_frac_ext;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]        w_y;

    assign w_advance   = !r_out_valid || out_ready;
    assign in_ready    = !r_s1_valid || w_advance;
    assign w_accept    = in_valid && in_ready;

    assign lut_address = r_s1_x[IN_WIDTH-1 -: ADDR_WIDTH];
    assign w_frac      = r_s1_x[FRAC_WIDTH-1:0];

    // Interpolation result always lies between base and next, so the
    // truncation back to DATA_WIDTH never wraps.
    assign w_diff      = $signed({lut_next[DATA_WIDTH-1], lut_next})
                       - $signed({lut_base[DATA_WIDTH-1], lut_base});
    assign w_diff_ext  = {{FRAC_WIDTH{w_diff[DATA_WIDTH]}}, w_diff};
    assign w_frac_ext  = {{(DATA_WIDTH + 1){1'b0}}, w_frac};
    assign w_prod      = w_diff_ext * w_frac_ext;
    assign w_y         = lut_base + DATA_WIDTH'(w_prod >>> FRAC_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_x      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                r_s1_x     <= in_data;
                r_s1_valid <= 1'b1;
            end else if (w_advance) begin
                r_s1_valid <= 1'b0;
            end

            if (w_advance) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_y;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_lut_interp_activation.sv
// tb/tb_lut_interp_activation.sv - self-checking bench for lut_interp_activation
module tb_lut_interp_activation;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] lut_address;
    logic [7:0] lut_base;
    logic [7:0] lut_next;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [7:0] lut [16];
    logic              ov_mode = 1'b0;
    int                ov_base = 0;
    int                ov_next = 0;

    logic [7:0] exp_q [$];
    logic       seen_in_ready;
    logic       popped;
    logic [7:0] pop_data;

    always #5 clk = ~clk;

    lut_interp_activation dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .lut_address (lut_address),
        .lut_base    (lut_base),
        .lut_next    (lut_next),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    // LUT environment: wraps 15->0, clamps at top positive segment 7
    always_comb begin
        if (ov_mode) begin
            lut_base = 8'(ov_base);
            lut_next = 8'(ov_next);
        end else begin
            lut_base = lut[lut_address];
            lut_next = (lut_address == 4'd7) ? lut[7] : lut[lut_address + 4'd1];
        end
    end

    function automatic logic [7:0] exp_y(input logic [7:0] x);
        int a, f, b, n, d, q;
        a = int'(x[7:4]);
        f = int'(x[3:0]);
        if (ov_mode) begin
            b = ov_base;
            n = ov_next;
        end else begin
            b = lut[a];
            n = (a == 7) ? b : int'(lut[(a + 1) % 16]);
        end
        d = (n - b) * f;
        q = (d >= 0) ? d / 16 : -((-d + 15) / 16);
        return 8'(b + q);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        seen_in_ready = in_ready;
        popped        = 1'b0;
        if (out_valid && out_ready) begin
            popped   = 1'b1;
            pop_data = out_data;
            chk("sb_expected_output", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("sb_data", out_data, exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(exp_y(d));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (exp_q.size() > 0 || out_valid); i++) step(1'b0, 8'h00, 1'b1);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_out_valid", out_valid, 0);
    endtask

    task automatic single(input logic [7:0] x, input logic [7:0] e);
        step(1'b1, x, 1'b1);
        chk("single_in_ready", seen_in_ready, 1);
        chk("single_addr", lut_address, x[7:4]);
        chk("single_early_valid", out_valid, 0);
        step(1'b0, 8'h00, 1'b1);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, e);
        step(1'b0, 8'h00, 1'b1);
        chk("single_popped", popped, 1);
    endtask

    initial begin
        logic [7:0] pops [$];
        int         npop;

        for (int i = 0; i < 16; i++) lut[i] = (i < 8) ? 8'(16 * i) : 8'sd0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_addr", lut_address, 0);
        @(negedge clk);

        single(8'h25, 8'd37);
        single(8'h7F, 8'd112);
        single(8'hF8, 8'd0);

        ov_mode = 1'b1;
        ov_base = 50;
        ov_next = 20;
        single(8'h03, 8'd44);
        drain();
        ov_mode = 1'b0;

        // back-to-back streaming
        step(1'b1, 8'h10, 1'b1);
        chk("stream_rdy0", seen_in_ready, 1);
        step(1'b1, 8'h18, 1'b1);
        chk("stream_rdy1", seen_in_ready, 1);
        step(1'b1, 8'h20, 1'b1);
        chk("stream_rdy2", seen_in_ready, 1);
        chk("stream_pop0", {popped, pop_data}, {1'b1, 8'd16});
        step(1'b0, 8'h00, 1'b1);
        chk("stream_pop1", {popped, pop_data}, {1'b1, 8'd24});
        step(1'b0, 8'h00, 1'b1);
        chk("stream_pop2", {popped, pop_data}, {1'b1, 8'd32});
        drain();

        // backpressure: four stalled cycles, three items offered
        step(1'b1, 8'h30, 1'b0);
        chk("bp_acc_a", seen_in_ready, 1);
        step(1'b1, 8'h40, 1'b0);
        chk("bp_acc_b", seen_in_ready, 1);
        step(1'b1, 8'h50, 1'b0);
        chk("bp_block_c0", seen_in_ready, 0);
        chk("bp_hold_data0", out_data, 48);
        chk("bp_addr0", lut_address, 4);
        step(1'b1, 8'h50, 1'b0);
        chk("bp_block_c1", seen_in_ready, 0);
        chk("bp_hold_data1", out_data, 48);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_addr1", lut_address, 4);
        step(1'b1, 8'h50, 1'b1);
        chk("bp_acc_c", seen_in_ready, 1);
        if (popped) pops.push_back(pop_data);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (popped) pops.push_back(pop_data);
        end
        chk("bp_count", pops.size(), 3);
        if (pops.size() == 3) begin
            chk("bp_order0", pops[0], 48);
            chk("bp_order1", pops[1], 64);
            chk("bp_order2", pops[2], 80);
        end

        // reset with both stages full
        step(1'b1, 8'h60, 1'b0);
        step(1'b1, 8'h70, 1'b0);
        chk("mid_full_valid", out_valid, 1);
        chk("mid_full_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_addr", lut_address, 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        npop = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (popped) npop++;
        end
        chk("mid_no_stale", npop, 0);
        single(8'h25, 8'd37);

        // randomized traffic against a random LUT
        for (int i = 0; i < 16; i++) lut[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
